// File: rtl/ringbuf_pkg.sv
// ringbuf_pkg: default geometry and width helpers shared by the ring buffer files
package ringbuf_pkg;
  localparam int DEF_WIDTH      = 24;
  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_NCH        = 2;
  function automatic int lvl_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction
  function automatic int ch_w(input int nch);
    return nch > 1 ? $clog2(nch) : 1;
  endfunction
endpackage

// File: rtl/ringbuf_mem.sv
// ringbuf_mem: frame storage with one write port and one registered single-channel read port
module ringbuf_mem #(
  parameter int WIDTH = 24,
  parameter int AW    = 4,
  parameter int NCH   = 2,
  parameter int CW    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [NCH*WIDTH-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  input  logic [CW-1:0]        ch,
  output logic [WIDTH-1:0]     rdata
);
  logic [NCH*WIDTH-1:0] mem [2**AW];
  // storage is deliberately left unreset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read sees pre-write contents; output holds between requests
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr][ch*WIDTH +: WIDTH];
endmodule

// File: rtl/mch_ringbuf.sv
// mch_ringbuf: multichannel frame ring buffer with look-back reads; RINGBUF_GUARD_EN drops writes when full instead of overwriting
module mch_ringbuf
  import ringbuf_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int NCH        = DEF_NCH,
  localparam int CW        = ch_w(NCH),
  localparam int LW        = lvl_w(DEPTH_LOG2),
  localparam int DEPTH     = 2**DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*WIDTH-1:0]  data_i,
  input  logic                  we_i,
  input  logic                  pop_i,
  input  logic                  re_i,
  input  logic [CW-1:0]         ch_i,
  input  logic [DEPTH_LOG2-1:0] offset_i,
  input  logic                  clr_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  output logic [LW-1:0]         level_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  ovf_o,
  output logic                  udf_o
);
  logic [DEPTH_LOG2-1:0] wptr, rptr, raddr;
  logic [LW-1:0] level_nx;
  logic [CW-1:0] ch_sel;
  logic ovf_set, udf_set, pop_ok, wr_ok, adv_r;
  // accept/drop decisions for this cycle's write and pop
  always_comb begin
    full_o   = level_o == LW'(DEPTH);
    empty_o  = level_o == '0;
    ovf_set  = we_i & full_o & ~pop_i;
    udf_set  = pop_i & empty_o & ~we_i;
    pop_ok   = pop_i & ~udf_set;
`ifdef RINGBUF_GUARD_EN
    wr_ok    = we_i & ~ovf_set;
    adv_r    = pop_ok;
`else
    wr_ok    = we_i;
    adv_r    = pop_ok | ovf_set;
`endif
    level_nx = (wr_ok & ~pop_ok & ~full_o) ? level_o + LW'(1) :
               (pop_ok & ~wr_ok)           ? level_o - LW'(1) : level_o;
    raddr    = rptr - offset_i;
    ch_sel   = (32'(ch_i) >= NCH) ? '0 : ch_i;
  end
  // pointers, occupancy and sticky flags; a set beats a same-cycle clear
  always_ff @(posedge clk)
    if (rst) begin
      wptr    <= '0;
      rptr    <= '1;
      level_o <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
      udf_o   <= 1'b0;
    end else begin
      wptr    <= wptr + DEPTH_LOG2'(wr_ok);
      rptr    <= rptr + DEPTH_LOG2'(adv_r);
      level_o <= level_nx;
      valid_o <= re_i;
      ovf_o   <= ovf_set | (ovf_o & ~clr_i);
      udf_o   <= udf_set | (udf_o & ~clr_i);
    end
  ringbuf_mem #(.WIDTH(WIDTH), .AW(DEPTH_LOG2), .NCH(NCH), .CW(CW)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok & ~rst),
    .waddr (wptr),
    .wdata (data_i),
    .re    (re_i & ~rst),
    .raddr (raddr),
    .ch    (ch_sel),
    .rdata (data_o)
  );
endmodule

// File: tb/tb_mch_ringbuf.sv
// tb_mch_ringbuf: directed stimulus against a frame-level model, checked every cycle, plus literal spot checks
module tb_mch_ringbuf;
  logic clk = 0;
  logic rst = 1;
  logic [47:0] data_i = '0;
  logic we_i = 0, pop_i = 0, re_i = 0, clr_i = 0;
  logic ch_i = 0;
  logic [3:0] offset_i = '0;
  logic [23:0] data_o;
  logic valid_o, full_o, empty_o, ovf_o, udf_o;
  logic [4:0] level_o;
  int n_cmp = 0, n_fail = 0;
  mch_ringbuf dut (
    .clk(clk), .rst(rst), .data_i(data_i), .we_i(we_i), .pop_i(pop_i), .re_i(re_i),
    .ch_i(ch_i), .offset_i(offset_i), .clr_i(clr_i), .data_o(data_o), .valid_o(valid_o),
    .level_o(level_o), .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );
  always #5 clk = ~clk;
  logic [47:0] m [16];
  int wp, rp, lvl;
  logic [23:0] ed;
  logic ev, eo, eu, model_ok = 0;
  always @(posedge clk) begin
    if (rst) begin
      wp = 0; rp = 15; lvl = 0; ev = 0; ed = 0; eo = 0; eu = 0; model_ok = 1;
    end else begin
      ev = re_i;
      if (re_i) ed = m[(rp - offset_i) & 15][ch_i*24 +: 24];
      eo = (we_i && lvl == 16 && !pop_i) || (eo && !clr_i);
      eu = (pop_i && lvl == 0 && !we_i) || (eu && !clr_i);
      if (we_i && lvl == 16 && !pop_i) begin
`ifndef RINGBUF_GUARD_EN
        m[wp] = data_i; wp = (wp + 1) % 16; rp = (rp + 1) % 16;
`endif
      end else if (we_i && pop_i) begin
        m[wp] = data_i; wp = (wp + 1) % 16; rp = (rp + 1) % 16;
      end else if (we_i) begin
        m[wp] = data_i; wp = (wp + 1) % 16; lvl++;
      end else if (pop_i && lvl > 0) begin
        rp = (rp + 1) % 16; lvl--;
      end
    end
  end
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (model_ok) begin
    cmp("m_level", 32'(level_o), 32'(lvl));
    cmp("m_full", 32'(full_o), 32'(lvl == 16));
    cmp("m_empty", 32'(empty_o), 32'(lvl == 0));
    cmp("m_ovf", 32'(ovf_o), 32'(eo));
    cmp("m_udf", 32'(udf_o), 32'(eu));
    cmp("m_valid", 32'(valid_o), 32'(ev));
    cmp("m_data", 32'(data_o), 32'(ed));
  end
  task automatic tick(input logic w, input logic [47:0] d, input logic p, input logic r,
                      input logic c, input logic [3:0] o, input logic cl);
    we_i = w; data_i = d; pop_i = p; re_i = r; ch_i = c; offset_i = o; clr_i = cl;
    @(posedge clk); #1;
    we_i = 0; pop_i = 0; re_i = 0; clr_i = 0;
  endtask
  task automatic do_reset();
    rst = 1; tick(0, 0, 0, 0, 0, 0, 0); tick(0, 0, 0, 0, 0, 0, 0); rst = 0;
  endtask
  task automatic seq_basic();
    for (int k = 0; k < 4; k++) tick(1, {24'(32'h100 + k), 24'(k)}, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 0, 0);
    cmp("basic_data", 32'(data_o), 32'h100);
    cmp("basic_valid", 32'(valid_o), 1);
    cmp("basic_level", 32'(level_o), 3);
    tick(0, 0, 0, 0, 0, 0, 0);
    cmp("hold_data", 32'(data_o), 32'h100);
    cmp("hold_valid", 32'(valid_o), 0);
  endtask
  initial begin
    do_reset();
    cmp("rst_level", 32'(level_o), 0);
    cmp("rst_valid", 32'(valid_o), 0);
    cmp("rst_data", 32'(data_o), 0);
    cmp("rst_empty", 32'(empty_o), 1);
    seq_basic();
    do_reset();
    for (int k = 0; k < 16; k++) tick(1, {24'(32'h300 + k), 24'(32'h200 + k)}, 0, 0, 0, 0, 0);
    cmp("fill_full", 32'(full_o), 1);
    cmp("fill_level", 32'(level_o), 16);
    tick(1, {24'h0, 24'hAAA}, 1, 1, 0, 4'd15, 0);
    cmp("rbw_data", 32'(data_o), 32'h200);
    cmp("wp_full_level", 32'(level_o), 16);
    cmp("wp_full_ovf", 32'(ovf_o), 0);
    for (int k = 0; k < 16; k++) tick(0, 0, 1, 0, 0, 0, 0);
    cmp("drain_empty", 32'(empty_o), 1);
    tick(0, 0, 1, 0, 0, 0, 0);
    cmp("udf_set", 32'(udf_o), 1);
    cmp("udf_level", 32'(level_o), 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    cmp("udf_clr", 32'(udf_o), 0);
    tick(1, 48'h5, 1, 0, 0, 0, 0);
    cmp("wp_empty_level", 32'(level_o), 0);
    cmp("wp_empty_udf", 32'(udf_o), 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    cmp("clr_idle", 32'({ovf_o, udf_o}), 0);
    do_reset();
    for (int k = 0; k < 16; k++) tick(1, 48'(k), 0, 0, 0, 0, 0);
`ifdef RINGBUF_GUARD_EN
    tick(1, 48'hABCDEF, 0, 0, 0, 0, 1);
    cmp("ovf_set", 32'(ovf_o), 1);
    cmp("ovf_level", 32'(level_o), 16);
    for (int k = 0; k < 16; k++) begin
      tick(0, 0, 1, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0, 0, 0);
      cmp("guard_read", 32'(data_o), 32'(k));
    end
`else
    tick(1, 48'd16, 0, 0, 0, 0, 1);
    cmp("ovf_set", 32'(ovf_o), 1);
    cmp("ovf_level", 32'(level_o), 16);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0, 0);
    cmp("ovw_read", 32'(data_o), 1);
    tick(0, 0, 0, 1, 0, 4'd1, 0);
    cmp("ovw_back", 32'(data_o), 16);
`endif
    tick(0, 0, 0, 0, 0, 0, 1);
    cmp("ovf_clr", 32'(ovf_o), 0);
    do_reset();
    for (int k = 0; k < 3; k++) tick(1, 48'(k + 7), 0, 1, 0, 0, 0);
    rst = 1;
    tick(1, 48'h9, 1, 1, 0, 0, 0);
    rst = 0;
    cmp("midrst_valid", 32'(valid_o), 0);
    cmp("midrst_level", 32'(level_o), 0);
    seq_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mch_ringbuf.md
MCH_RINGBUF -- requirements
Module: mch_ringbuf

Interface
REQ-001 Parameter WIDTH, default 24, sample width in bits.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of frame depth; DEPTH = 2**DEPTH_LOG2.
REQ-003 Parameter NCH, default 2, channels per frame; minimum 1.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 data_i  in  NCH*WIDTH  write frame; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 we_i  in  1  write-enable; stores one frame.
REQ-008 pop_i  in  1  advances the read pointer by one frame.
REQ-009 re_i  in  1  read request.
REQ-010 ch_i  in  max(1,clog2(NCH))  channel selected for the read.
REQ-011 offset_i  in  DEPTH_LOG2  look-back distance from the read pointer.
REQ-012 clr_i  in  1  clears sticky flags.
REQ-013 data_o  out  WIDTH  registered read data.
REQ-014 valid_o  out  1  data_o qualifier.
REQ-015 level_o  out  DEPTH_LOG2+1  unpopped frames, 0..DEPTH.
REQ-016 full_o / empty_o  out  1 each  level_o==DEPTH / level_o==0.
REQ-017 ovf_o / udf_o  out  1 each  sticky overflow / underflow flags.

Function
REQ-018 Write pointer wptr SHALL store data_i at frame wptr and increment modulo DEPTH on an accepted write.
REQ-019 Read pointer rptr SHALL point to the most recently popped frame and increment modulo DEPTH on an accepted pop.
REQ-020 On re_i, read address SHALL be (rptr - offset_i) mod DEPTH, channel ch_i; data_o and valid_o SHALL update exactly 1 cycle later; valid_o SHALL be low in cycles with no request.
REQ-021 data_o SHALL hold its last value while valid_o is low.
REQ-022 A read of the frame written in the same cycle SHALL return the old contents (read-before-write).
REQ-023 Pop with level_o==0 and no simultaneous write SHALL be ignored and set udf_o.
REQ-024 Pop with level_o==0 and a simultaneous write SHALL be accepted; level_o stays 0.
REQ-025 Write with pop both accepted SHALL leave level_o unchanged, including when full.
REQ-026 Write alone SHALL increment level_o; pop alone SHALL decrement it, subject to REQ-023 and REQ-028/029.
REQ-027 ch_i >= NCH SHALL return channel 0.
REQ-028 Write when full, no pop, with RINGBUF_GUARD_EN defined: write dropped, pointers and level unchanged, ovf_o set.
REQ-029 Write when full, no pop, without RINGBUF_GUARD_EN: oldest frame overwritten, wptr and rptr both advance, level_o stays DEPTH, ovf_o set.
REQ-030 clr_i SHALL clear ovf_o and udf_o; a set event in the same cycle SHALL take priority.

Reset
REQ-031 rst SHALL set wptr=0, rptr=DEPTH-1, level_o=0, valid_o=0, data_o=0, ovf_o=0, udf_o=0.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 rst SHALL override all inputs in the same cycle; a read in flight during reset SHALL NOT assert valid_o.

Configuration
REQ-034 Macro RINGBUF_GUARD_EN defined: full-write protection per REQ-028.
REQ-035 Macro RINGBUF_GUARD_EN undefined: overwrite per REQ-029.
REQ-036 All other behaviour SHALL be identical in both builds.

Structure
REQ-037 Package ringbuf_pkg SHALL hold the default WIDTH/DEPTH_LOG2/NCH constants and a level-width helper function.
REQ-038 Sub-module ringbuf_mem SHALL implement the NCH*WIDTH x DEPTH array with one write port and one registered read port.
REQ-039 Pointers, level counter and flags SHALL live in mch_ringbuf.

Verification (WIDTH=24, DEPTH_LOG2=4, NCH=2)
REQ-040 After reset, write frames k=0..3 as {ch1=0x100+k, ch0=k}, then pop once, re_i ch_i=1 offset_i=0 -> next cycle data_o=0x000100, valid_o=1, level_o=3.
REQ-041 Write 16 frames, no pops -> full_o=1, level_o=16; pop 16 times -> empty_o=1; one further pop -> udf_o=1, level_o=0.
REQ-042 Guard build: 16 writes then a 17th of 0xABCDEF -> ovf_o=1, level_o=16, and after popping all 16 frames 0xABCDEF is never read.
REQ-043 Non-guard build: 17 writes of k=0..16 -> ovf_o=1, level_o=16; first pop then offset_i=0 read of ch0 -> 1.
REQ-044 Simultaneous we_i+pop_i at level 0 and at level 16 -> level_o unchanged, no flag set; clr_i with no event -> flags 0.
REQ-045 Assert rst mid-burst with re_i high -> next cycle valid_o=0, level_o=0, then REQ-040 sequence passes again.
